// File: rtl/hdmi_video_pkg.sv
// Shared definitions for the HDMI video source: pattern mode encodings,
// colour type and the colour-bar palette.
package hdmi_video_pkg;

  typedef logic [23:0] colour_t;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_RAMP  = 2'd3;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam colour_t BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  localparam colour_t GRID_COLOUR = 24'h404040;
  localparam colour_t WHITE       = 24'hFFFFFF;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counters plus active/sync/frame-wrap decode for an
// arbitrary resolution; all decode outputs describe the current count.
module hdmi_timing_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           reset,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           origin,
  output logic           frame_wrap
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START   = H_ACTIVE + H_FP;
  localparam int HS_END     = HS_START + H_SYNC;
  localparam int VS_START   = V_ACTIVE + V_FP;
  localparam int VS_END     = VS_START + V_SYNC;

  generate
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
      $error("hdmi_timing_counter: H_SYNC and V_SYNC must be non-zero");
    end
  endgenerate

  logic [H_W-1:0] h_cnt_reg;
  logic [V_W-1:0] v_cnt_reg;
  logic           h_last;
  logic           v_last;

  assign h_last = (int'(h_cnt_reg) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_reg) == V_TOTAL - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_last) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  // Compared as int so sync windows ending exactly at the total never overflow.
  assign active     = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
  assign hsync      = (int'(h_cnt_reg) >= HS_START) && (int'(h_cnt_reg) < HS_END);
  assign vsync      = (int'(v_cnt_reg) >= VS_START) && (int'(v_cnt_reg) < VS_END);
  assign origin     = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign frame_wrap = h_last && v_last;
  assign h_cnt      = h_cnt_reg;
  assign v_cnt      = v_cnt_reg;

endmodule

// File: rtl/hdmi_video_gen.sv
// Parametrised HDMI video source: raster timing, sync and test patterns, all
// outputs registered and aligned. Optional grid overlay: HDMI_GRID_OVERLAY_EN.
module hdmi_video_gen
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int CHECK_SHIFT = 4,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W        = $clog2(H_TOTAL),
  localparam int V_W        = $clog2(V_TOTAL)
) (
  input  logic           pixclk,
  input  logic           reset,
  input  logic [1:0]     mode,
  input  logic [23:0]    solid_rgb,
  output logic [7:0]     R_data,
  output logic [7:0]     G_data,
  output logic [7:0]     B_data,
  output logic           VDE,
  output logic [1:0]     CD,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [1:0] CD_IDLE = {~VSYNC_POL, ~HSYNC_POL};

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           active, hsync, vsync, origin, frame_wrap;

  hdmi_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk(pixclk), .reset(reset),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .active(active), .hsync(hsync), .vsync(vsync),
    .origin(origin), .frame_wrap(frame_wrap)
  );

  // Captured on the edge that moves the counters to (0,0), so the new
  // selection is in force for the whole of the frame that follows.
  logic [1:0] mode_reg;
  colour_t    solid_reg;

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      mode_reg  <= MODE_SOLID;
      solid_reg <= '0;
    end else if (frame_wrap) begin
      mode_reg  <= mode;
      solid_reg <= solid_rgb;
    end
  end

  logic [2:0] bar_idx;
  colour_t    pattern;
  colour_t    rgb_next;

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (int'(h_cnt) >= i * BAR_W) bar_idx = 3'(i);
    end

    pattern = solid_reg;
    case (mode_reg)
      MODE_SOLID: pattern = solid_reg;
      MODE_BARS:  pattern = BAR_COLOURS[bar_idx];
      MODE_CHECK: pattern = (h_cnt[CHECK_SHIFT] ^ v_cnt[CHECK_SHIFT]) ? WHITE : '0;
      MODE_RAMP:  pattern = {3{8'(h_cnt)}};
      default:    pattern = solid_reg;
    endcase

    rgb_next = active ? pattern : '0;
`ifdef HDMI_GRID_OVERLAY_EN
    if (active && (h_cnt[CHECK_SHIFT-1:0] == '0 || v_cnt[CHECK_SHIFT-1:0] == '0))
      rgb_next = GRID_COLOUR;
`endif
  end

  logic [H_W-1:0] x_reg;
  logic [V_W-1:0] y_reg;
  logic           vde_reg, fs_reg;
  logic [1:0]     cd_reg, cd_next;
  colour_t        rgb_reg;

  assign cd_next = {vsync ? VSYNC_POL : ~VSYNC_POL, hsync ? HSYNC_POL : ~HSYNC_POL};

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      x_reg   <= '0;
      y_reg   <= '0;
      vde_reg <= 1'b0;
      cd_reg  <= CD_IDLE;
      rgb_reg <= '0;
      fs_reg  <= 1'b0;
    end else begin
      x_reg   <= h_cnt;
      y_reg   <= v_cnt;
      vde_reg <= active;
      cd_reg  <= cd_next;
      rgb_reg <= rgb_next;
      fs_reg  <= origin;
    end
  end

  assign R_data      = rgb_reg[23:16];
  assign G_data      = rgb_reg[15:8];
  assign B_data      = rgb_reg[7:0];
  assign VDE         = vde_reg;
  assign CD          = cd_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign frame_start = fs_reg;

endmodule
